johnson_decoder: RTL and testbench
==================================

Name: johnson_decoder

Overview:
- Receiving end of the ring/Johnson counter interface.
- Samples a WIDTH-bit Johnson code (q1 = MSB) every clock and decodes it to a binary phase index.
- Checks that each code is legal and that consecutive codes follow the Johnson sequence.
- Tracks a lock state and keeps a saturating error count, so downstream logic can trust or reject the counter.

Parameters:
- WIDTH, 3, Johnson code width; legal sequence length = 2*WIDTH.
- LOCK_CNT, 4, consecutive legal advances required to enter LOCKED (1..15).
- ERR_W, 8, width of saturating error counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous reset, active-high.
- code  input  WIDTH  Johnson code from counter, code[WIDTH-1] = q1.
- clr_err  input  1  synchronous clear of err_cnt.
- idx  output  IW=$clog2(2*WIDTH)  decoded phase index 0..2*WIDTH-1.
- idx_valid  output  1  idx corresponds to a legal code this cycle.
- illegal  output  1  one-cycle pulse: sampled code not in legal set.
- step_err  output  1  one-cycle pulse: legal code that is neither a hold nor the successor of the previous legal code.
- locked  output  1  high in LOCKED state.
- err_cnt  output  ERR_W  saturating count of illegal + step_err events.

Behaviour:
- Legal sequence, index i, shift-left with inverted-MSB feedback: i=0 all zeros; i=1..WIDTH fills ones from the LSB; i=WIDTH+1..2*WIDTH-1 clears ones from the LSB.
  - WIDTH=3: 000(0), 001(1), 011(2), 111(3), 110(4), 100(5), then wrap to 000.
- Pipeline:
  - Stage 1 registers code into code_r.
  - Stage 2 decodes code_r and registers all outputs.
  - Latency from code input to outputs is 2 clocks.
- Decode:
  - Legal code: idx = i, idx_valid = 1.
  - Illegal code: idx holds its last value, idx_valid = 0, illegal = 1.
- Step check:
  - Compare against prev_idx, the index of the last legal code.
  - Legal if new == prev (hold) or new == prev+1 mod 2*WIDTH. Wrap 2*WIDTH-1 -> 0 is legal.
  - Any other legal code: step_err = 1, and prev_idx is updated to the new index.
  - First legal code after reset or after an illegal code: no step check, prev_valid set.
  - An illegal code clears prev_valid.
- Lock state machine, with a 4-bit advance counter adv_cnt:
  - UNLOCKED: each legal advance (not a hold) increments adv_cnt. When adv_cnt reaches LOCK_CNT, go to LOCKED.
  - LOCKED: holds and advances stay LOCKED. illegal or step_err -> UNLOCKED and adv_cnt = 0.
  - An error in UNLOCKED resets adv_cnt to 0.
- err_cnt:
  - Increments by 1 per cycle when illegal|step_err, and saturates at all-ones.
  - clr_err has priority over increment: if both occur in the same cycle, the result is 0.
- Reset (synchronous, active-high):
  - code_r = 0, prev_idx = 0, prev_valid = 0, adv_cnt = 0, state UNLOCKED.
  - Outputs: idx = 0, idx_valid = 0, illegal = 0, step_err = 0, locked = 0, err_cnt = 0.
  - Reset mid-operation discards the pipeline contents; the first valid output appears 2 clocks after reset deasserts.

Optional Feature:
- Macro: JOHNSON_DEC_REVERSE_EN.
- Defined:
  - A step to prev-1 mod 2*WIDTH is also legal and counts as an advance toward lock.
  - Adds output dir (1 bit, reset 0): 1 = last advance was reverse, 0 = forward. dir is unchanged on holds.
  - A direction change while LOCKED is not an error.
- Undefined: reverse steps raise step_err; port dir is absent.

Test Plan:
- Reset, then a clean forward sequence 000,001,011,111,110,100,000 (WIDTH=3, LOCK_CNT=4):
  - idx = 0,1,2,3,4,5,0 with 2-clock latency.
  - locked rises on the output cycle of the 4th advance (code 110).
  - err_cnt = 0.
- Hold 011 for 5 cycles while LOCKED -> idx = 2 constant, no step_err, locked stays 1.
- Inject 010 while LOCKED:
  - illegal pulse for 1 cycle, idx_valid = 0, idx holds, locked -> 0, err_cnt = 1.
  - Next code 111 is accepted without step_err.
- Skip 001 -> 111:
  - step_err pulse, err_cnt increments, locked drops.
  - Four further advances relock.
- ERR_W=2: force 5 errors -> err_cnt = 3 (saturated); clr_err together with an error in the same cycle -> err_cnt = 0.
- With JOHNSON_DEC_REVERSE_EN: sequence 110,111,011 -> no step_err, dir = 1. Without the macro: step_err on 111.

Source files
------------

// File: rtl/johnson_decoder_if.sv
// Bus between a Johnson counter (master) and johnson_decoder (slave).
// The dir signal exists only when JOHNSON_DEC_REVERSE_EN is defined.
interface johnson_decoder_if #(
  parameter int WIDTH = 3,
  parameter int ERR_W = 8
);
  localparam int IW = $clog2(2 * WIDTH);

  logic [WIDTH-1:0] code;
  logic             clr_err;
  logic [IW-1:0]    idx;
  logic             idx_valid;
  logic             illegal;
  logic             step_err;
  logic             locked;
  logic [ERR_W-1:0] err_cnt;
`ifdef JOHNSON_DEC_REVERSE_EN
  logic             dir;

  modport master (output code, clr_err,
                  input  idx, idx_valid, illegal, step_err, locked, err_cnt, dir);
  modport slave  (input  code, clr_err,
                  output idx, idx_valid, illegal, step_err, locked, err_cnt, dir);
`else
  modport master (output code, clr_err,
                  input  idx, idx_valid, illegal, step_err, locked, err_cnt);
  modport slave  (input  code, clr_err,
                  output idx, idx_valid, illegal, step_err, locked, err_cnt);
`endif
endinterface

// File: rtl/johnson_decoder.sv
// Two-stage Johnson code decoder with sequence checking, lock tracking and error count.
// Define JOHNSON_DEC_REVERSE_EN to accept reverse steps and add the dir output.
module johnson_decoder #(
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  johnson_decoder_if.slave   bus
);
  localparam int N  = 2 * WIDTH;
  localparam int IW = $clog2(N);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  function automatic logic [WIDTH-1:0] jcode(input int i);
    logic [WIDTH-1:0] ones;
    ones = '1;
    if (i <= WIDTH) return ones >> (WIDTH - i);
    else            return ones << (i - WIDTH);
  endfunction

  logic [WIDTH-1:0] code_reg;
  logic             s1_valid_reg;
  logic [IW-1:0]    prev_idx_reg, prev_idx_next;
  logic             prev_valid_reg, prev_valid_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic             idx_valid_reg, idx_valid_next;
  logic             illegal_reg, illegal_next;
  logic             step_err_reg, step_err_next;
  logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;
  logic [3:0]       adv_cnt_reg, adv_cnt_next;
  state_t           state_reg, state_next;
  logic             advance, err;
  logic [N-1:0]     hit;
  logic             legal;
  logic [IW-1:0]    dec_idx, succ;
`ifdef JOHNSON_DEC_REVERSE_EN
  logic [IW-1:0]    pred;
  logic             dir_reg, dir_next;
`endif

  // Stage 1: capture the raw code; s1_valid_reg keeps reset contents out of stage 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      code_reg     <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      code_reg     <= bus.code;
      s1_valid_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_match
    localparam logic [WIDTH-1:0] PAT = jcode(gi);
    assign hit[gi] = (code_reg == PAT);
  end

  always_comb begin
    legal   = 1'b0;
    dec_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (hit[i]) begin
        legal   = 1'b1;
        dec_idx = IW'(i);
      end
    end
  end

  assign succ = (prev_idx_reg == IW'(N - 1)) ? '0 : prev_idx_reg + 1'b1;
`ifdef JOHNSON_DEC_REVERSE_EN
  assign pred = (prev_idx_reg == '0) ? IW'(N - 1) : prev_idx_reg - 1'b1;
`endif

  // Stage 2: decode and step check against the last legal index.
  always_comb begin
    prev_idx_next   = prev_idx_reg;
    prev_valid_next = prev_valid_reg;
    idx_next        = idx_reg;
    idx_valid_next  = 1'b0;
    illegal_next    = 1'b0;
    step_err_next   = 1'b0;
    advance         = 1'b0;
`ifdef JOHNSON_DEC_REVERSE_EN
    dir_next        = dir_reg;
`endif
    if (s1_valid_reg) begin
      if (!legal) begin
        illegal_next    = 1'b1;
        prev_valid_next = 1'b0;
      end else begin
        idx_next        = dec_idx;
        idx_valid_next  = 1'b1;
        prev_idx_next   = dec_idx;
        prev_valid_next = 1'b1;
        if (prev_valid_reg && (dec_idx != prev_idx_reg)) begin
          if (dec_idx == succ) begin
            advance = 1'b1;
`ifdef JOHNSON_DEC_REVERSE_EN
            dir_next = 1'b0;
          end else if (dec_idx == pred) begin
            advance  = 1'b1;
            dir_next = 1'b1;
`endif
          end else begin
            step_err_next = 1'b1;
          end
        end
      end
    end
  end

  assign err = illegal_next | step_err_next;

  always_comb begin
    state_next   = state_reg;
    adv_cnt_next = adv_cnt_reg;
    case (state_reg)
      UNLOCKED: begin
        if (err) begin
          adv_cnt_next = '0;
        end else if (advance) begin
          if (({1'b0, adv_cnt_reg} + 5'd1) >= 5'(LOCK_CNT)) begin
            state_next   = LOCKED;
            adv_cnt_next = '0;
          end else begin
            adv_cnt_next = adv_cnt_reg + 4'd1;
          end
        end
      end
      default: begin
        if (err) begin
          state_next   = UNLOCKED;
          adv_cnt_next = '0;
        end
      end
    endcase
  end

  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (bus.clr_err)                     err_cnt_next = '0;
    else if (err && (err_cnt_reg != '1)) err_cnt_next = err_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_idx_reg   <= '0;
      prev_valid_reg <= 1'b0;
      idx_reg        <= '0;
      idx_valid_reg  <= 1'b0;
      illegal_reg    <= 1'b0;
      step_err_reg   <= 1'b0;
      err_cnt_reg    <= '0;
      adv_cnt_reg    <= '0;
      state_reg      <= UNLOCKED;
`ifdef JOHNSON_DEC_REVERSE_EN
      dir_reg        <= 1'b0;
`endif
    end else begin
      prev_idx_reg   <= prev_idx_next;
      prev_valid_reg <= prev_valid_next;
      idx_reg        <= idx_next;
      idx_valid_reg  <= idx_valid_next;
      illegal_reg    <= illegal_next;
      step_err_reg   <= step_err_next;
      err_cnt_reg    <= err_cnt_next;
      adv_cnt_reg    <= adv_cnt_next;
      state_reg      <= state_next;
`ifdef JOHNSON_DEC_REVERSE_EN
      dir_reg        <= dir_next;
`endif
    end
  end

  assign bus.idx       = idx_reg;
  assign bus.idx_valid = idx_valid_reg;
  assign bus.illegal   = illegal_reg;
  assign bus.step_err  = step_err_reg;
  assign bus.locked    = (state_reg == LOCKED);
  assign bus.err_cnt   = err_cnt_reg;
`ifdef JOHNSON_DEC_REVERSE_EN
  assign bus.dir       = dir_reg;
`endif
endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder: behavioural model feeds a scoreboard,
// and each scenario task adds direct checks of the expected values.
module tb_johnson_decoder;
  localparam int WIDTH    = 3;
  localparam int LOCK_CNT = 4;
  localparam int ERR_W    = 2;
  localparam int N        = 2 * WIDTH;
  localparam int IW       = $clog2(N);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  johnson_decoder_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

  johnson_decoder #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [IW-1:0]    idx;
    logic             idx_valid;
    logic             illegal;
    logic             step_err;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;
    logic             dir;
  } out_t;

  out_t sb_q[$];
  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] seq [N];

  // model state
  logic [WIDTH-1:0] m_code;
  bit m_s1v, m_pvld, m_locked, m_dir;
  int m_prev, m_adv, m_err, m_idx;

  function automatic int decode(input logic [WIDTH-1:0] c);
    for (int i = 0; i < N; i++) if (seq[i] === c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_code = '0; m_s1v = 0; m_pvld = 0; m_locked = 0; m_dir = 0;
    m_prev = 0; m_adv = 0; m_err = 0; m_idx = 0;
    sb_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.code = '0; bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
  endtask

  // One clock: drive inputs, model the output produced at this edge, compare.
  task automatic cycle(input logic [WIDTH-1:0] c, input logic clr);
    out_t e, got;
    int d;
    bit ill, se, adv;
    reset = 1'b0; bus.code = c; bus.clr_err = clr;
    ill = 0; se = 0; adv = 0; e = '0;
    if (m_s1v) begin
      d = decode(m_code);
      if (d < 0) begin
        ill = 1; m_pvld = 0;
      end else begin
        e.idx_valid = 1'b1; m_idx = d;
        if (m_pvld && d != m_prev) begin
          if (d == (m_prev + 1) % N) begin adv = 1; m_dir = 0; end
`ifdef JOHNSON_DEC_REVERSE_EN
          else if (d == (m_prev + N - 1) % N) begin adv = 1; m_dir = 1; end
`endif
          else se = 1;
        end
        m_prev = d; m_pvld = 1;
      end
    end
    if (ill || se) begin
      m_locked = 0; m_adv = 0;
    end else if (adv && !m_locked) begin
      m_adv++;
      if (m_adv >= LOCK_CNT) begin m_locked = 1; m_adv = 0; end
    end
    if (clr) m_err = 0;
    else if ((ill || se) && m_err < (1 << ERR_W) - 1) m_err++;
    e.idx = IW'(m_idx); e.illegal = ill; e.step_err = se; e.locked = m_locked;
    e.err_cnt = ERR_W'(m_err);
`ifdef JOHNSON_DEC_REVERSE_EN
    e.dir = m_dir;
`endif
    sb_q.push_back(e);
    m_code = c; m_s1v = 1;
    @(posedge clk);
    #1;
    got = '0;
    got.idx = bus.idx; got.idx_valid = bus.idx_valid; got.illegal = bus.illegal;
    got.step_err = bus.step_err; got.locked = bus.locked; got.err_cnt = bus.err_cnt;
`ifdef JOHNSON_DEC_REVERSE_EN
    got.dir = bus.dir;
`endif
    e = sb_q.pop_front();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL sb code_in=%b got idx=%0d v=%b ill=%b se=%b lk=%b err=%0d dir=%b required idx=%0d v=%b ill=%b se=%b lk=%b err=%0d dir=%b",
               c, got.idx, got.idx_valid, got.illegal, got.step_err, got.locked, got.err_cnt, got.dir,
               e.idx, e.idx_valid, e.illegal, e.step_err, e.locked, e.err_cnt, e.dir);
    end else begin
      $display("txn code_in=%b clr=%b idx=%0d v=%b ill=%b se=%b lk=%b err=%0d",
               c, clr, got.idx, got.idx_valid, got.illegal, got.step_err, got.locked, got.err_cnt);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.idx, bus.idx_valid, bus.illegal, bus.step_err, bus.locked, bus.err_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got idx=%0d v=%b ill=%b se=%b lk=%b err=%0d required all zero",
               bus.idx, bus.idx_valid, bus.illegal, bus.step_err, bus.locked, bus.err_cnt);
    end
    cycle(3'b001, 1'b0);
    checks++;
    if (bus.idx_valid !== 1'b0) begin
      failures++; $display("FAIL reset_latency1 got v=%b required 0", bus.idx_valid);
    end
    cycle(3'b001, 1'b0);
    checks++;
    if (bus.idx_valid !== 1'b1 || bus.idx !== 3'd1) begin
      failures++; $display("FAIL reset_latency2 got v=%b idx=%0d required v=1 idx=1", bus.idx_valid, bus.idx);
    end
  endtask

  task automatic test_forward();
    logic [WIDTH-1:0] codes [8];
    int exp_idx [7];
    bit exp_lk [7];
    codes   = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000, 3'b000};
    exp_idx = '{0, 1, 2, 3, 4, 5, 0};
    exp_lk  = '{0, 0, 0, 0, 1, 1, 1};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      cycle(codes[k], 1'b0);
      if (k >= 2) begin
        checks++;
        if (bus.idx !== IW'(exp_idx[k-1]) || bus.locked !== exp_lk[k-1] || bus.err_cnt !== '0) begin
          failures++;
          $display("FAIL fwd_%0d got idx=%0d lk=%b err=%0d required idx=%0d lk=%b err=0",
                   k - 1, bus.idx, bus.locked, bus.err_cnt, exp_idx[k-1], exp_lk[k-1]);
        end
      end
    end
  endtask

  task automatic test_hold();
    cycle(3'b001, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cycle(3'b011, 1'b0);
      if (k >= 1) begin
        checks++;
        if (bus.idx !== 3'd2 || bus.step_err !== 1'b0 || bus.locked !== 1'b1) begin
          failures++;
          $display("FAIL hold_%0d got idx=%0d se=%b lk=%b required idx=2 se=0 lk=1",
                   k, bus.idx, bus.step_err, bus.locked);
        end
      end
    end
  endtask

  task automatic test_illegal();
    cycle(3'b011, 1'b1);
    cycle(3'b010, 1'b0);
    cycle(3'b111, 1'b0);
    checks++;
    if (bus.illegal !== 1'b1 || bus.idx_valid !== 1'b0 || bus.idx !== 3'd2 ||
        bus.locked !== 1'b0 || bus.err_cnt !== 2'd1) begin
      failures++;
      $display("FAIL illegal_pulse got ill=%b v=%b idx=%0d lk=%b err=%0d required ill=1 v=0 idx=2 lk=0 err=1",
               bus.illegal, bus.idx_valid, bus.idx, bus.locked, bus.err_cnt);
    end
    cycle(3'b111, 1'b0);
    checks++;
    if (bus.illegal !== 1'b0 || bus.step_err !== 1'b0 || bus.idx !== 3'd3 || bus.idx_valid !== 1'b1) begin
      failures++;
      $display("FAIL illegal_recover got ill=%b se=%b idx=%0d v=%b required ill=0 se=0 idx=3 v=1",
               bus.illegal, bus.step_err, bus.idx, bus.idx_valid);
    end
  endtask

  task automatic test_skip();
    logic [WIDTH-1:0] c [10];
    c = '{3'b110, 3'b100, 3'b000, 3'b001, 3'b111, 3'b110, 3'b100, 3'b000, 3'b001, 3'b001};
    for (int j = 0; j < 10; j++) begin
      cycle(c[j], 1'b0);
      if (j == 4) begin
        checks++;
        if (bus.locked !== 1'b1) begin
          failures++; $display("FAIL skip_prelock got lk=%b required 1", bus.locked);
        end
      end
      if (j == 5) begin
        checks++;
        if (bus.step_err !== 1'b1 || bus.locked !== 1'b0 || bus.err_cnt !== 2'd2 || bus.idx !== 3'd3) begin
          failures++;
          $display("FAIL skip_err got se=%b lk=%b err=%0d idx=%0d required se=1 lk=0 err=2 idx=3",
                   bus.step_err, bus.locked, bus.err_cnt, bus.idx);
        end
      end
      if (j == 8 || j == 9) begin
        checks++;
        if (bus.locked !== (j == 9)) begin
          failures++; $display("FAIL skip_relock_%0d got lk=%b required %b", j, bus.locked, j == 9);
        end
      end
    end
  endtask

  task automatic test_saturate();
    logic [WIDTH-1:0] c [6];
    c = '{3'b010, 3'b101, 3'b010, 3'b101, 3'b010, 3'b000};
    cycle(3'b001, 1'b1);
    for (int j = 0; j < 6; j++) cycle(c[j], 1'b0);
    checks++;
    if (bus.err_cnt !== 2'd3 || bus.illegal !== 1'b1) begin
      failures++; $display("FAIL saturate got err=%0d ill=%b required err=3 ill=1", bus.err_cnt, bus.illegal);
    end
    cycle(3'b010, 1'b0);
    cycle(3'b000, 1'b1);
    checks++;
    if (bus.err_cnt !== 2'd0 || bus.illegal !== 1'b1) begin
      failures++; $display("FAIL clr_priority got err=%0d ill=%b required err=0 ill=1", bus.err_cnt, bus.illegal);
    end
    cycle(3'b000, 1'b0);
    checks++;
    if (bus.step_err !== 1'b0 || bus.idx_valid !== 1'b1 || bus.err_cnt !== 2'd0) begin
      failures++;
      $display("FAIL post_clr got se=%b v=%b err=%0d required se=0 v=1 err=0", bus.step_err, bus.idx_valid, bus.err_cnt);
    end
  endtask

  task automatic test_reverse();
    do_reset();
    cycle(3'b110, 1'b0);
    cycle(3'b111, 1'b0);
    cycle(3'b011, 1'b0);
    checks++;
`ifdef JOHNSON_DEC_REVERSE_EN
    if (bus.step_err !== 1'b0 || bus.dir !== 1'b1 || bus.idx !== 3'd3) begin
      failures++; $display("FAIL reverse got se=%b dir=%b idx=%0d required se=0 dir=1 idx=3", bus.step_err, bus.dir, bus.idx);
    end
`else
    if (bus.step_err !== 1'b1 || bus.idx !== 3'd3) begin
      failures++; $display("FAIL reverse got se=%b idx=%0d required se=1 idx=3", bus.step_err, bus.idx);
    end
`endif
    cycle(3'b011, 1'b0);
  endtask

  task automatic test_back_to_back();
    cycle(3'b001, 1'b0);
    cycle(3'b011, 1'b0);
    do_reset();
    cycle(3'b111, 1'b0);
    checks++;
    if (bus.idx_valid !== 1'b0 || bus.idx !== 3'd0) begin
      failures++; $display("FAIL midreset_flush got v=%b idx=%0d required v=0 idx=0", bus.idx_valid, bus.idx);
    end
    cycle(3'b111, 1'b0);
    checks++;
    if (bus.idx_valid !== 1'b1 || bus.idx !== 3'd3 || bus.step_err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_first got v=%b idx=%0d se=%b required v=1 idx=3 se=0", bus.idx_valid, bus.idx, bus.step_err);
    end
    for (int j = 0; j < 40; j++) cycle(seq[$urandom_range(N - 1)], 1'($urandom_range(7) == 0));
  endtask

  initial begin
    logic [WIDTH-1:0] cur;
    cur = '0;
    for (int i = 0; i < N; i++) begin
      seq[i] = cur;
      cur = {cur[WIDTH-2:0], ~cur[WIDTH-1]};
    end
    reset = 1'b1; bus.code = '0; bus.clr_err = 1'b0;
    test_reset();
    test_forward();
    test_hold();
    test_illegal();
    test_skip();
    test_saturate();
    test_reverse();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
